// File: rtl/mel_log_compress.sv
// ---------------------------------------------------------------------------
// mel_log_compress
//
// Log-compression stage placed after the mel filter bank. It accepts one
// frame of N_BINS unsigned mel energies over a valid/ready handshake. It then
// computes a fixed-point log2 of each band, one band per clock, using a
// leading-one detector and a Mitchell (linear) mantissa. Finally it presents
// the finished frame to the downstream DCT stage.
//
// Ports:
//   clk      - single clock, all state updates on the rising edge
//   reset    - synchronous, active-high
//   in       - N_BINS x IN_W unsigned energies, sampled on the accepting edge
//   s_valid  - upstream frame valid
//   s_ready  - block can accept a frame (IDLE)
//   out      - N_BINS x OUT_W log2 results, unsigned, held after completion
//   m_valid  - out holds a complete frame (DONE)
//   m_ready  - downstream accepts the frame
// ---------------------------------------------------------------------------
module mel_log_compress #(
    parameter int N_BINS = 40,
    parameter int IN_W   = 16,
    parameter int FRAC_W = 8,
    parameter int OUT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [IN_W-1:0]   in  [0:N_BINS-1],
    input  logic              s_valid,
    output logic              s_ready,
    output logic [OUT_W-1:0]  out [0:N_BINS-1],
    output logic              m_valid,
    input  logic              m_ready
);

    localparam int IDX_W = (N_BINS > 1) ? $clog2(N_BINS) : 1;
    localparam int P_W   = $clog2(IN_W);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COMPUTE,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [IDX_W-1:0]   r_idx;
    logic [IN_W-1:0]    r_buf [0:N_BINS-1];
    logic [OUT_W-1:0]   r_out [0:N_BINS-1];

    logic               w_accept;
    logic               w_last;
    logic [IN_W-1:0]    w_sel;
    logic [P_W-1:0]     w_p;
    logic [P_W-1:0]     w_shamt;
    logic [IN_W-1:0]    w_norm;
    logic [FRAC_W-1:0]  w_mant;
    logic [OUT_W-1:0]   w_log;

    assign w_accept = (r_state == S_IDLE) && s_valid;
    assign w_last   = (r_state == S_COMPUTE) && (r_idx == IDX_W'(N_BINS - 1));

    // Handshake outputs come straight from the state register only.
    assign s_ready = (r_state == S_IDLE);
    assign m_valid = (r_state == S_DONE);

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:    if (s_valid) w_state_next = S_COMPUTE;
            S_COMPUTE: if (w_last)  w_state_next = S_DONE;
            S_DONE:    if (m_ready) w_state_next = S_IDLE;
            default:   w_state_next = S_IDLE;
        endcase
    end

    // Bin index. It wraps to 0 after the last bin so it always addresses a
    // valid buffer entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx <= '0;
        end else if (w_accept || w_last) begin
            r_idx <= '0;
        end else if (r_state == S_COMPUTE) begin
            r_idx <= r_idx + IDX_W'(1);
        end
    end

    // ------------------------------------------------------------- LOG2
    assign w_sel = r_buf[r_idx];

    // Leading-one position. Both x=0 and x=1 give p=0.
    always_comb begin
        w_p = '0;
        for (int i = 1; i < IN_W; i++) begin
            if (w_sel[i]) w_p = P_W'(i);
        end
    end

    // Normalise so the leading one sits at the MSB. The bits below it form
    // the mantissa. Extra zeros are appended so the left-alignment pads with
    // zeros when p < FRAC_W. The final cast drops the leading one and
    // truncates the low bits (no rounding).
    assign w_shamt = P_W'(IN_W - 1) - w_p;
    assign w_norm  = w_sel << w_shamt;
    assign w_mant  = FRAC_W'({w_norm, {FRAC_W{1'b0}}} >> (IN_W - 1));
    assign w_log   = OUT_W'({w_p, w_mant});

    // ------------------------------------------------- frame buffer / out
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_BINS; i++) begin
                r_buf[i] <= '0;
                r_out[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_BINS; i++) begin
                if (w_accept) begin
                    r_buf[i] <= in[i];
                end
                if ((r_state == S_COMPUTE) && (r_idx == IDX_W'(i))) begin
                    r_out[i] <= w_log;
                end
            end
        end
    end

    assign out = r_out;

endmodule

// File: tb/tb_mel_log_compress.sv
// ---------------------------------------------------------------------------
// tb_mel_log_compress
//
// Scoreboard bench for mel_log_compress. One watcher process pushes the
// expected frame into a queue when it sees a frame being accepted. The
// expected values come from an arithmetic log2 reference model. A monitor
// process pops and compares those values whenever the DUT hands a frame
// downstream. The main process drives directed and randomised stimulus.
// ---------------------------------------------------------------------------
module tb_mel_log_compress;

    localparam int N = 40;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        s_valid = 1'b0;
    logic        m_ready = 1'b0;
    logic        s_ready;
    logic        m_valid;
    logic [15:0] din  [0:N-1];
    logic [15:0] dout [0:N-1];

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mel_log_compress #(
        .N_BINS (N),
        .IN_W   (16),
        .FRAC_W (8),
        .OUT_W  (16)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .in      (din),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .out     (dout),
        .m_valid (m_valid),
        .m_ready (m_ready)
    );

    // Reference: integer part is floor(log2 x). The fraction is
    // (x - 2^p) / 2^p scaled by 256 and floored.
    function automatic int ref_log2(input int x);
        int p;
        int frac;
        if (x <= 1) return 0;
        p = 0;
        while ((1 << (p + 1)) <= x) p++;
        frac = ((x - (1 << p)) * 256) / (1 << p);
        return p * 256 + frac;
    endfunction

    logic [15:0] exp_q [$];
    int  last_accept = -1;
    int  prev_btb    = -1;
    bit  btb_mode    = 0;
    bit  sweep_mode  = 0;
    int  sweep_prev  = 0;
    bit  mv_prev     = 0;
    logic [15:0] mon_exp;

    // Acceptance watcher: the coming edge accepts the frame on din.
    always @(negedge clk) begin
        if (s_valid && s_ready && !reset) begin
            for (int i = 0; i < N; i++) exp_q.push_back(16'(ref_log2(int'(din[i]))));
            last_accept = cyc + 1;
            if (btb_mode) begin
                if (prev_btb >= 0) begin
                    tests++;
                    if (last_accept - prev_btb != 42) begin
                        fails++;
                        $display("FAIL btb_period: got %0d cycles, expected 42", last_accept - prev_btb);
                    end
                end
                prev_btb = last_accept;
            end
        end
    end

    // Monitor: latency check on m_valid rise, scoreboard compare on handoff.
    always @(negedge clk) begin
        if (m_valid && !mv_prev && last_accept >= 0) begin
            tests++;
            if (cyc - last_accept != 40) begin
                fails++;
                $display("FAIL latency: got %0d cycles, expected 40", cyc - last_accept);
            end
        end
        if (m_valid && m_ready && !reset) begin
            if (exp_q.size() < N) begin
                tests++;
                fails++;
                $display("FAIL unexpected_frame: got m_valid with %0d expected words queued, expected %0d", exp_q.size(), N);
            end else begin
                for (int i = 0; i < N; i++) begin
                    mon_exp = exp_q.pop_front();
                    tests++;
                    if (dout[i] !== mon_exp) begin
                        fails++;
                        $display("FAIL bin[%0d]: got 0x%0h expected 0x%0h", i, dout[i], mon_exp);
                    end
                    if (sweep_mode) begin
                        tests++;
                        if (int'(dout[i]) < sweep_prev) begin
                            fails++;
                            $display("FAIL monotonic bin[%0d]: got 0x%0h after 0x%0h", i, dout[i], sweep_prev);
                        end
                        sweep_prev = int'(dout[i]);
                    end
                end
            end
        end
        mv_prev = m_valid;
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int got, input int expv);
        tests++;
        if (got != expv) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, expv);
        end
    endtask

    task automatic wait_ready();
        int g = 0;
        while (!s_ready && g < 200) begin
            tick();
            g++;
        end
        if (!s_ready) check("wait_ready_timeout", 0, 1);
    endtask

    task automatic send();
        wait_ready();
        s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
    endtask

    task automatic drain();
        int g = 0;
        while (exp_q.size() != 0 && g < 500) begin
            tick();
            g++;
        end
        check("drain_queue", exp_q.size(), 0);
    endtask

    function automatic int count_nonzero();
        int nz = 0;
        for (int i = 0; i < N; i++) if (dout[i] != 16'h0) nz++;
        return nz;
    endfunction

    initial begin
        #1_000_000;
        fails++;
        $display("FAIL global_timeout: got no finish, expected finish");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "timeout");
    end

    initial begin
        int kin  [0:6];
        int kout [0:6];
        int g;
        int bad;
        int v;

        kin  = '{0, 1, 2, 3, 1000, 'h8000, 'hFFFF};
        kout = '{'h000, 'h000, 'h100, 'h180, 'h9F4, 'hF00, 'hFFF};
        for (int i = 0; i < N; i++) din[i] = 16'h0;

        // Reset then idle
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        for (int c = 0; c < 10; c++) begin
            check("idle_s_ready", int'(s_ready), 1);
            check("idle_m_valid", int'(m_valid), 0);
            check("idle_out_nonzero", count_nonzero(), 0);
            tick();
        end

        // Known values, then backpressure
        for (int i = 0; i < N; i++) din[i] = (i < 7) ? 16'(kin[i]) : 16'h1;
        m_ready = 1'b0;
        send();
        for (int i = 0; i < N; i++) din[i] = 16'h1234;
        g = 0;
        while (!m_valid && g < 60) begin
            tick();
            g++;
        end
        check("known_m_valid", int'(m_valid), 1);
        s_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            bad = 0;
            for (int i = 0; i < N; i++) begin
                if (int'(dout[i]) != ((i < 7) ? kout[i] : 0)) begin
                    bad++;
                    $display("FAIL known_bin[%0d]: got 0x%0h expected 0x%0h", i, dout[i], (i < 7) ? kout[i] : 0);
                end
            end
            tests++;
            if (bad != 0) fails++;
            check("bp_m_valid", int'(m_valid), 1);
            check("bp_s_ready", int'(s_ready), 0);
            tick();
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        tick();
        check("handoff_s_ready", int'(s_ready), 1);
        check("handoff_m_valid", int'(m_valid), 0);

        // Back-to-back frames A/B with s_valid and m_ready tied high
        btb_mode = 1;
        prev_btb = -1;
        for (int i = 0; i < N; i++) din[i] = 16'h0100;
        s_valid = 1'b1;
        for (int f = 0; f < 6; f++) begin
            wait_ready();
            tick();
            for (int i = 0; i < N; i++) din[i] = (f % 2 == 0) ? 16'h00FF : 16'h0100;
        end
        s_valid = 1'b0;
        drain();
        btb_mode = 0;
        tick(3);

        // Reset mid-operation at idx=20, with a frame presented during reset
        for (int i = 0; i < N; i++) din[i] = 16'($urandom_range(2, 65535));
        send();
        tick(20);
        reset = 1'b1;
        s_valid = 1'b1;
        for (int i = 0; i < N; i++) din[i] = 16'($urandom_range(2, 65535));
        tick();
        reset = 1'b0;
        s_valid = 1'b0;
        exp_q.delete();
        check("abort_s_ready", int'(s_ready), 1);
        check("abort_m_valid", int'(m_valid), 0);
        check("abort_out_nonzero", count_nonzero(), 0);
        bad = 0;
        for (int c = 0; c < 45; c++) begin
            if (m_valid) bad++;
            tick();
        end
        check("abort_m_valid_cycles", bad, 0);
        for (int i = 0; i < N; i++) din[i] = 16'($urandom_range(0, 65535));
        send();
        drain();

        // Random frames of mixed magnitude with random downstream stall
        for (int f = 0; f < 6; f++) begin
            for (int i = 0; i < N; i++) din[i] = 16'($urandom_range(0, 65535) >> $urandom_range(0, 15));
            m_ready = 1'b0;
            send();
            tick($urandom_range(40, 60));
            m_ready = 1'b1;
            drain();
        end

        // Monotonicity sweep across 0..0xFFFF (step 13, ending at 0xFFFF)
        sweep_mode = 1;
        sweep_prev = 0;
        m_ready = 1'b1;
        v = 0;
        do begin
            for (int i = 0; i < N; i++) begin
                din[i] = (v > 65535) ? 16'hFFFF : 16'(v);
                v += 13;
            end
            send();
        end while (din[N-1] != 16'hFFFF);
        drain();
        sweep_mode = 0;

        check("final_queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
